// File: rtl/scan_display_mux.sv
// scan_display_mux: time-multiplexed display driver.
// It runs its own refresh counter and steps the digit select. At each
// frame wrap it takes a snapshot of the digit inputs, so a frame never
// mixes old and new values. It drives active-low anodes, blanks every
// digit slot at its start, and can suppress leading zeros. Every output
// is registered from (sel, cnt, snapshot).
module scan_display_mux #(
  parameter int DIGITS      = 8,
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int SEL_W       = $clog2(DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DIGITS*WIDTH-1:0] d_bus,
  input  logic [DIGITS-1:0]       dp_in,
  input  logic [DIGITS-1:0]       digit_en,
  input  logic                    lz_en,
  output logic [WIDTH-1:0]        Y,
  output logic [SEL_W-1:0]        sel,
  output logic [DIGITS-1:0]       an,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic                    load_pending;
  logic                    slot_end;
  logic                    wrap;
  logic                    snap_take;

  // Snapshot of every input that affects the display.
  logic [DIGITS*WIDTH-1:0] sh_dig;
  logic [DIGITS-1:0]       sh_dp;
  logic [DIGITS-1:0]       sh_en;
  logic                    sh_lz;

  logic [DIGITS-1:0]       supp;
  logic                    zero_above;
  logic                    in_blank;
  logic                    lit;

  assign slot_end  = (cnt == CNT_LAST);
  assign wrap      = slot_end && (sel == SEL_LAST);
  // The first clock after reset loads the snapshot at once, so the
  // display does not have to wait a whole frame for real data.
  assign snap_take = wrap || load_pending;

  // Refresh counter, digit walk and frame pulse. The load_pending load
  // is not a wrap, so it never raises frame_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      sel          <= '0;
      frame_done   <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      frame_done   <= wrap;
      load_pending <= 1'b0;
      if (slot_end) begin
        cnt <= '0;
        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Tear-free frame snapshot: inputs are sampled only at the wrap or by
  // the post-reset load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_en  <= '0;
      sh_lz  <= 1'b0;
    end else if (snap_take) begin
      sh_dig <= d_bus;
      sh_dp  <= dp_in;
      sh_en  <= digit_en;
      sh_lz  <= lz_en;
    end
  end

  // Leading-zero mask: walk down from the MSB while every digit so far
  // is zero. Digit 0 always stays visible, so a zero value still shows "0".
  always_comb begin
    zero_above = 1'b1;
    supp       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (sh_dig[k*WIDTH +: WIDTH] == '0);
      supp[k]    = sh_lz & zero_above & (k != 0);
    end
  end

  // Anti-ghosting window at the start of each slot. It is removed when
  // BLANK_CYC is zero, which also avoids an always-false compare.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < BLANK_LIM);
    end
  endgenerate

  assign lit = ~in_blank & sh_en[sel] & ~supp[sel];

  // Registered output stage. Y and dp_n follow the scanned digit even
  // while its anode is off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Y    <= '0;
      an   <= '1;
      dp_n <= 1'b1;
    end else begin
      Y    <= sh_dig[int'(sel)*WIDTH +: WIDTH];
      dp_n <= ~sh_dp[sel];
      an   <= lit ? ~(DIGITS'(1) << sel) : '1;
    end
  end

endmodule

// File: tb/tb_scan_display_mux.sv
// Bench for scan_display_mux with DIGITS=4, WIDTH=4 and REFRESH_DIV=4.
// Two instances run side by side from the same inputs, one with
// BLANK_CYC=1 and one with BLANK_CYC=0. The reference model works from
// the elapsed clock count after reset release. It uses the frame period
// to find the scanned slot and the snapshot time.
module tb_scan_display_mux;

  localparam int D  = 4;
  localparam int W  = 4;
  localparam int RD = 4;
  localparam int F  = D * RD;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [D*W-1:0] d_bus;
  logic [D-1:0]   dp_in;
  logic [D-1:0]   digit_en;
  logic           lz_en;

  logic [W-1:0] y1, y0;
  logic [1:0]   sel1, sel0;
  logic [D-1:0] an1, an0;
  logic         dpn1, dpn0, fd1, fd0;

  scan_display_mux #(.DIGITS(D), .WIDTH(W), .REFRESH_DIV(RD), .BLANK_CYC(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .d_bus(d_bus), .dp_in(dp_in),
    .digit_en(digit_en), .lz_en(lz_en), .Y(y1), .sel(sel1), .an(an1),
    .dp_n(dpn1), .frame_done(fd1)
  );

  scan_display_mux #(.DIGITS(D), .WIDTH(W), .REFRESH_DIV(RD), .BLANK_CYC(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .d_bus(d_bus), .dp_in(dp_in),
    .digit_en(digit_en), .lz_en(lz_en), .Y(y0), .sel(sel0), .an(an0),
    .dp_n(dpn0), .frame_done(fd0)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int e      = 0;     // rising edges since reset release
  logic [D*W-1:0] sh_d;
  logic [D-1:0]   sh_dp, sh_en;
  logic           sh_lz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Expected registered outputs for the display state (slot ps, count pc).
  function automatic void model_out(input int blank, input int ps, input int pc,
                                    output logic [W-1:0] ey, output logic [D-1:0] ean,
                                    output logic edpn);
    logic [D*W-1:0] upper;
    logic           dark;
    upper = sh_d >> (ps * W);
    ey    = upper[W-1:0];
    edpn  = ~sh_dp[ps];
    dark  = (pc < blank) || !sh_en[ps] || (sh_lz && ps != 0 && upper == 0);
    ean   = dark ? {D{1'b1}} : ~(D'(1) << ps);
  endfunction

  task automatic clear_model();
    e     = 0;
    sh_d  = '0;
    sh_dp = '0;
    sh_en = '0;
    sh_lz = 1'b0;
  endtask

  // driver + checker for one clock
  task automatic step();
    logic [W-1:0] ey1, ey0;
    logic [D-1:0] ean1, ean0;
    logic         edp1, edp0;
    @(posedge clk);
    model_out(1, (e / RD) % D, e % RD, ey1, ean1, edp1);
    model_out(0, (e / RD) % D, e % RD, ey0, ean0, edp0);
    e++;
    if (e == 1 || e % F == 0) begin
      sh_d  = d_bus;
      sh_dp = dp_in;
      sh_en = digit_en;
      sh_lz = lz_en;
    end
    #1;
    check("b1_y",   32'(y1),   32'(ey1));
    check("b1_an",  32'(an1),  32'(ean1));
    check("b1_dpn", 32'(dpn1), 32'(edp1));
    check("b1_sel", 32'(sel1), 32'((e / RD) % D));
    check("b1_fd",  32'(fd1),  32'(e % F == 0));
    check("b0_y",   32'(y0),   32'(ey0));
    check("b0_an",  32'(an0),  32'(ean0));
    check("b0_dpn", 32'(dpn0), 32'(edp0));
    check("b0_sel", 32'(sel0), 32'((e / RD) % D));
    check("b0_fd",  32'(fd0),  32'(e % F == 0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"},  32'(an1),  32'hF);
    check({tag, "_y"},   32'(y1),   32'h0);
    check({tag, "_dpn"}, 32'(dpn1), 32'h1);
    check({tag, "_fd"},  32'(fd1),  32'h0);
    check({tag, "_sel"}, 32'(sel1), 32'h0);
    check({tag, "_an0"}, 32'(an0),  32'hF);
    check({tag, "_fd0"}, 32'(fd0),  32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    d_bus    = 16'h4321;
    dp_in    = 4'h0;
    digit_en = 4'hF;
    lz_en    = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // load, slot order and three frames of frame_done
    repeat (3 * F) step();

    // mid-frame input change stays hidden until the next wrap
    while ((e / RD) % D != 2) step();
    d_bus = 16'h8765;
    repeat (2 * F) step();

    // leading-zero suppression
    d_bus = 16'h0070;
    lz_en = 1'b1;
    repeat (2 * F) step();
    d_bus = 16'h0000;
    repeat (2 * F) step();

    // digit mask and decimal point
    lz_en    = 1'b0;
    d_bus    = 16'h9A5C;
    digit_en = 4'b1011;
    dp_in    = 4'b0010;
    repeat (2 * F) step();

    // randomized inputs, skewed toward values with leading zeros
    repeat (20 * F) begin
      if ($urandom_range(0, 5) == 0) begin
        d_bus    = 16'($urandom_range(0, 65535) >> ($urandom_range(0, 4) * 4));
        dp_in    = 4'($urandom_range(0, 15));
        digit_en = 4'($urandom_range(0, 15));
        lz_en    = 1'($urandom_range(0, 1));
      end
      step();
    end

    // asynchronous reset in the middle of the scan
    while ((e / RD) % D != 3) step();
    reset_n = 1'b0;
    clear_model();
    #1 check_reset_vals("midrst");
    @(posedge clk);
    #1 check_reset_vals("midrst_hold");
    @(negedge clk);
    d_bus    = 16'h1234;
    digit_en = 4'hF;
    lz_en    = 1'b0;
    reset_n  = 1'b1;
    repeat (2 * F) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_display_mux.md
Name: scan_display_mux

Overview:
- Parametrised, time-multiplexed display driver: the sequential successor to the team's fixed 8:1 4-bit digit mux.
- Owns its own refresh counter and walks the digit select itself.
- Captures a tear-free per-frame snapshot of all digit values.
- Drives active-low anode enables with anti-ghosting blanking and optional leading-zero suppression.
- Sits between the counter datapath and the 7-segment decoder/pins.

Parameters:
- DIGITS, 8, number of display digits/channels (2..16).
- WIDTH, 4, bits per digit value.
- REFRESH_DIV, 50000, clocks each digit is held before advancing (>= 2).
- BLANK_CYC, 500, clocks at the start of each digit slot with all anodes off (0 <= BLANK_CYC < REFRESH_DIV).
- SEL_W, clog2(DIGITS), width of select/index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- d_bus  in  DIGITS*WIDTH  digit values; digit i = d_bus[i*WIDTH +: WIDTH]; digit DIGITS-1 is most significant.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- digit_en  in  DIGITS  per-digit enable; 0 forces that digit dark.
- lz_en  in  1  leading-zero suppression enable.
- Y  out  WIDTH  value of the currently scanned digit, to the segment decoder.
- sel  out  SEL_W  index of the currently scanned digit.
- an  out  DIGITS  anode enables, active-low, at most one bit low.
- dp_n  out  1  decimal point, active-low.
- frame_done  out  1  one-clock pulse when the scan wraps from DIGITS-1 to 0.

Behaviour:
- Reset (async assert, sync-released by system): cnt=0, sel=0, shadow=0, load_pending=1, Y=0, an=all 1s, dp_n=1, frame_done=0.
- Refresh counter cnt: 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1: cnt<=0 and sel advances by 1.
  - Wrap: sel==DIGITS-1 -> 0. Non-power-of-2 DIGITS never reaches unused codes.
- Snapshot: shadow <= {d_bus, dp_in, digit_en, lz_en} on the wrap edge, or on the first clock with load_pending=1, which then clears load_pending.
  - Only shadow feeds the outputs.
  - Input changes mid-frame are invisible until the next wrap.
- frame_done = 1 for exactly the clock after the wrap edge, coincident with sel=0. Never asserted by the load_pending load.
- Output stage (all outputs registered, 1-clock latency from (sel, cnt, shadow)):
  - Y <= shadow digit[sel].
  - dp_n <= ~shadow dp[sel].
  - an <= all 1s if cnt < BLANK_CYC, or shadow digit_en[sel]==0, or digit sel is suppressed.
  - Otherwise an has only bit sel = 0.
  - Y and dp_n update even when dark.
- Leading-zero suppression: digit k is suppressed iff shadow lz_en=1, k != 0, and shadow digits DIGITS-1 down to k are all zero.
  - Digit 0 is never suppressed, so "0" still shows.
  - A dp request on a suppressed digit is not shown (anode off).
- BLANK_CYC=0: no blanking interval.
- Each digit is dark for BLANK_CYC clocks and lit for REFRESH_DIV-BLANK_CYC clocks.
- Reset mid-frame: all state returns to reset values immediately (async); scan restarts at digit 0 with a fresh snapshot.
- No combinational path from any input to any output.

Test Plan:
Use DIGITS=4, WIDTH=4, REFRESH_DIV=4, BLANK_CYC=1 unless stated.
- Reset/load: hold reset_n=0, release with d_bus=16'h4321, digit_en=4'hF, lz_en=0.
  - an=4'hF and Y=0 during reset.
  - After release, sel sequence 0,0,0,0,1,1,1,1,2,...
  - Lit slots show an=1110/Y=1, 1101/Y=2, 1011/Y=3, 0111/Y=4.
  - First registered cycle of each slot has an=1111.
- Wrap/frame_done: run 3 frames.
  - frame_done pulses once per 16 clocks, in the cycle sel returns to 0.
  - Never pulses during the post-reset load.
- Tear-free snapshot: change d_bus to 16'h8765 while sel=2.
  - Digits 2,3 still show 3,4.
  - Next frame shows 5,6,7,8.
- Leading zeros: d_bus=16'h0070, lz_en=1.
  - Digits 3 and 2 are dark (an=1111 in their slots).
  - Digit 1 shows 7, digit 0 shows 0.
  - d_bus=16'h0000 -> only digit 0 is lit, showing 0.
- Masks and dp: digit_en=4'b1011, dp_in=4'b0010.
  - Slot 2 is fully dark.
  - dp_n=0 only in slot 1.
  - Set BLANK_CYC=0: no dark cycles at slot boundaries.
- Mid-scan reset: assert reset_n=0 for 1 clock while sel=3.
  - an=1111 and frame_done=0 immediately.
  - After release, sel restarts at 0 and the snapshot is reloaded.
